mtimer_irq: RTL and testbench
=============================

// Module: mtimer_irq
// PURPOSE
//  Machine timer (mtime/mtimecmp) peripheral driving the timer-interrupt input of the CSR unit.
//  Memory-mapped on the data-bus side of the 3-stage pipeline.
//  mtime advances on a prescaled tick. A level interrupt is raised while mtime >= mtimecmp and the timer is enabled.
//  The `interrupt` output connects directly to the CSR unit's `interrupt` input, which sets mip.MTIP.
// PARAMETERS
//  PRESCALE_W   16  width of prescaler divisor field (ctrl[PRESCALE_W:1])
//  RST_CMP      64'hFFFF_FFFF_FFFF_FFFF  reset value of mtimecmp (no interrupt out of reset)
// PORTS
//  clk        in   1   single clock
//  rst        in   1   reset, asynchronous, active-low
//  req        in   1   bus request
//  we         in   1   1=write, 0=read (sampled with req)
//  addr       in   5   byte offset: 0x00 mtime_lo, 0x04 mtime_hi, 0x08 cmp_lo, 0x0C cmp_hi, 0x10 ctrl
//  wdata      in   32  write data
//  ready      out  1   request accepted this cycle (req & ready = transfer)
//  rvalid     out  1   read data/response valid, one cycle after an accepted read
//  rdata      out  32  read data (0 when rvalid=0)
//  err        out  1   qualifies rvalid / write ack: unmapped or misaligned offset
//  interrupt  out  1   registered timer interrupt level
// BEHAVIOUR
//  Clocking/reset: one clock; reset is asynchronous and active-low.
//  Reset values:
//   - mtime=0, mtimecmp=RST_CMP, ctrl=0 (enable=0, divisor=0), shadow_hi=0, prescale cnt=0.
//   - ready=1, rvalid=0, rdata=0, err=0, interrupt=0.
//  ctrl register:
//   - ctrl[0] = enable; ctrl[PRESCALE_W:1] = divisor D.
//   - A tick occurs every D+1 cycles while enabled.
//   - Prescale counter clears on any ctrl write and while enable=0.
//  Counting:
//   - On a tick, mtime <= mtime+1 (64-bit, wraps 2^64-1 -> 0 with no flag).
//  Writes:
//   - Take effect at the clock edge of the accepted transfer.
//   - A write to mtime_lo/hi in the same cycle as a tick wins: the written half takes wdata and the other half holds.
//   - No carry is applied that cycle.
//  Reads:
//   - 1-cycle latency: rvalid=1 and rdata registered in the cycle after acceptance.
//   - ready is held at 1, so back-to-back transfers are legal.
//  Atomic 64-bit read:
//   - Reading mtime_lo returns mtime[31:0] and latches mtime[63:32] into shadow_hi in the same edge.
//   - Reading mtime_hi returns shadow_hi, not live mtime.
//   - mtimecmp reads are live.
//  Writes respond with rvalid=1, rdata=0 the next cycle (write ack).
//  Unmapped offset (>0x10) or addr[1:0]!=0:
//   - No state change; rvalid=1, err=1, rdata=0.
//  Interrupt:
//   - interrupt <= enable & (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on the current register values.
//   - Asserts 1 cycle after the condition first holds.
//   - Deasserts 1 cycle after mtimecmp is raised above mtime, or enable is cleared.
//   - Level, not pulse: stays high until software clears the condition.
//  Reset mid-operation:
//   - All state returns to reset values immediately.
//   - A pending rvalid is dropped; interrupt falls asynchronously.
// STRUCTURE
//  Package mtimer_pkg:
//   - offset localparams (MTIME_LO..CTRL).
//   - typedef struct packed {logic [PRESCALE_W-1:0] div; logic en;} ctrl_t.
//  Sub-module tick_gen:
//   - Prescale counter; inputs en, div, clr; output 1-cycle tick.
//  Top level:
//   - Registers, bus decode, shadow_hi, compare flop.
// TESTING
//  1. Reset, then read all offsets -> mtime=0, cmp lo/hi=FFFF_FFFF, ctrl=0, interrupt=0, err=0.
//  2. ctrl=0x1 (D=0), cmp=5 -> mtime increments every cycle; interrupt rises 1 cycle after mtime reaches 5.
//     Then write cmp_lo=100 -> interrupt falls next cycle.
//  3. ctrl=(3<<1)|1 -> mtime increments exactly every 4 cycles.
//     Clearing enable freezes mtime; re-enabling restarts the prescaler from 0.
//  4. mtime=0x0000_0000_FFFF_FFFF, D=0 -> next tick gives 0x1_0000_0000.
//     Read lo at value 0xFFFF_FFFF, then hi after the wrap -> returns shadow 0 (atomic pair).
//  5. Write mtime_lo=0x10 coincident with a tick -> mtime_lo=0x10, no increment that cycle.
//     Read at addr 0x14 or 0x02 -> rvalid=1, err=1, rdata=0, no state change.
//  6. Assert rst low while interrupt=1 and a read is pending -> interrupt=0 and rvalid=0 without a clock edge.

Source files
------------

// File: rtl/mtimer_pkg.sv
// mtimer_pkg: register offsets and control register layout for the machine timer
package mtimer_pkg;
  localparam int PRESCALE_W = 16;
  localparam logic [4:0] MTIME_LO = 5'h00;
  localparam logic [4:0] MTIME_HI = 5'h04;
  localparam logic [4:0] CMP_LO   = 5'h08;
  localparam logic [4:0] CMP_HI   = 5'h0C;
  localparam logic [4:0] CTRL     = 5'h10;
  typedef struct packed {
    logic [PRESCALE_W-1:0] div;
    logic                  en;
  } ctrl_t;
endpackage

// File: rtl/mtimer_irq_tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every div+1 enabled cycles
module tick_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);
  logic [W-1:0] cnt;
  assign tick = en & (cnt == div);
  // count enabled cycles, restarting on a tick, a ctrl write or while disabled
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr | ~en | tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mtimer_irq.sv
// mtimer_irq: memory-mapped mtime/mtimecmp timer raising a level timer interrupt
module mtimer_irq
  import mtimer_pkg::*;
#(
  parameter logic [63:0] RST_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        interrupt
);
  logic [63:0] mtime, cmp;
  logic [31:0] shadow_hi, rd;
  ctrl_t       ctrl;
  logic        tick, bad, wr, rdo;
  assign ready = 1'b1;
  assign bad   = (addr[1:0] != 2'b00) | (addr > CTRL);
  assign wr    = req & we & ~bad;
  assign rdo   = req & ~we & ~bad;
  tick_gen #(.W(PRESCALE_W)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (ctrl.en),
    .clr (wr & (addr == CTRL)),
    .div (ctrl.div),
    .tick(tick)
  );
  // read mux; mtime_hi comes from the shadow so lo/hi pairs are atomic
  always_comb
    rd = (addr == MTIME_LO) ? mtime[31:0] :
         (addr == MTIME_HI) ? shadow_hi   :
         (addr == CMP_LO)   ? cmp[31:0]   :
         (addr == CMP_HI)   ? cmp[63:32]  : 32'(ctrl);
  // register file, bus response and interrupt flop; software writes to mtime beat the tick
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mtime     <= '0;
      cmp       <= RST_CMP;
      ctrl      <= '0;
      shadow_hi <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      if (wr && addr == MTIME_LO) mtime[31:0] <= wdata;
      else if (wr && addr == MTIME_HI) mtime[63:32] <= wdata;
      else if (tick) mtime <= mtime + 64'd1;
      if (wr && addr == CMP_LO) cmp[31:0] <= wdata;
      if (wr && addr == CMP_HI) cmp[63:32] <= wdata;
      if (wr && addr == CTRL) ctrl <= ctrl_t'(wdata[PRESCALE_W:0]);
      if (rdo && addr == MTIME_LO) shadow_hi <= mtime[63:32];
      rvalid    <= req;
      err       <= req & bad;
      rdata     <= rdo ? rd : '0;
      interrupt <= ctrl.en & (mtime >= cmp);
    end
endmodule

// File: tb/tb_mtimer_irq.sv
// tb_mtimer_irq: directed and random checks of mtimer_irq against a cycle reference model
module tb_mtimer_irq;
  logic        clk = 0, rst = 0, req = 0, we = 0;
  logic [4:0]  addr = 0;
  logic [31:0] wdata = 0, rdata;
  logic        ready, rvalid, err, interrupt;
  int n_chk = 0, n_fail = 0;
  logic [63:0] m_time, m_cmp;
  logic [31:0] m_shadow;
  bit          m_en;
  int unsigned m_div, m_el;
  mtimer_irq dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err), .interrupt(interrupt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_time = 0; m_cmp = '1; m_shadow = 0; m_en = 0; m_div = 0; m_el = 0;
  endtask
  // one bus cycle: predict from pre-edge model state, clock, then compare
  task automatic step(input bit rq, input bit w, input logic [4:0] a, input logic [31:0] d);
    bit bad, tick, e_irq;
    logic [31:0] e_rdata;
    logic [63:0] nt;
    req = rq; we = w; addr = a; wdata = d;
    bad = (a % 4 != 0) || (a > 16);
    tick = m_en && ((m_el + 1) % (m_div + 1) == 0);
    e_irq = m_en && (m_time >= m_cmp);
    e_rdata = 0;
    nt = tick ? m_time + 1 : m_time;
    if (rq && !bad && !w) begin
      if (a == 0) begin e_rdata = m_time[31:0]; m_shadow = m_time[63:32]; end
      else if (a == 4) e_rdata = m_shadow;
      else if (a == 8) e_rdata = m_cmp[31:0];
      else if (a == 12) e_rdata = m_cmp[63:32];
      else e_rdata = (m_div << 1) | 32'(m_en);
    end
    if (rq && !bad && w && a == 0) nt = {m_time[63:32], d};
    if (rq && !bad && w && a == 4) nt = {d, m_time[31:0]};
    if (rq && !bad && w && a == 8) m_cmp[31:0] = d;
    if (rq && !bad && w && a == 12) m_cmp[63:32] = d;
    if (rq && !bad && w && a == 16) begin
      m_en = d[0]; m_div = d[16:1]; m_el = 0;
    end else m_el = m_en ? m_el + 1 : 0;
    m_time = nt;
    @(posedge clk); #1;
    chk("rvalid", 64'(rvalid), 64'(rq));
    chk("err", 64'(err), 64'(rq && bad));
    chk("rdata", 64'(rdata), 64'(e_rdata));
    chk("interrupt", 64'(interrupt), 64'(e_irq));
    req = 0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_irq", 64'(interrupt), 64'd0);
    rst = 1;
    // reset values of every register
    for (int i = 0; i <= 16; i += 4) step(1, 0, 5'(i), 0);
    // D=0 counting with cmp=5: interrupt rises, then cmp raised
    step(1, 1, 5'h0C, 0);
    step(1, 1, 5'h08, 5);
    step(1, 1, 5'h10, 1);
    repeat (8) step(0, 0, 0, 0);
    step(1, 0, 5'h00, 0);
    step(1, 1, 5'h08, 100);
    repeat (2) step(0, 0, 0, 0);
    // D=3 prescale, freeze and restart
    step(1, 1, 5'h10, (3 << 1) | 1);
    for (int i = 0; i < 10; i++) step(1, 0, 5'h00, 0);
    step(1, 1, 5'h10, 3 << 1);
    repeat (3) step(1, 0, 5'h00, 0);
    step(1, 1, 5'h10, (3 << 1) | 1);
    for (int i = 0; i < 6; i++) step(1, 0, 5'h00, 0);
    // 32-bit carry and atomic lo/hi pair
    step(1, 1, 5'h10, 0);
    step(1, 1, 5'h00, 32'hFFFF_FFFF);
    step(1, 1, 5'h04, 0);
    step(1, 0, 5'h00, 0);
    step(1, 1, 5'h10, 1);
    step(1, 0, 5'h04, 0);
    step(1, 0, 5'h00, 0);
    step(1, 0, 5'h04, 0);
    // write coincident with tick, then error offsets
    step(1, 1, 5'h00, 32'h10);
    step(1, 0, 5'h00, 0);
    step(1, 0, 5'h14, 0);
    step(1, 0, 5'h02, 0);
    step(1, 1, 5'h02, 32'hDEAD);
    step(1, 1, 5'h1C, 32'hBEEF);
    step(1, 0, 5'h08, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 11);
      case (r)
        0, 1:    step(1, 0, 5'($urandom_range(0, 4) * 4), 0);
        2:       step(1, $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
        3:       step(1, 1, 5'h08, m_time[31:0] + $urandom_range(0, 12) - 4);
        4:       step(1, 1, 5'h0C, m_time[63:32]);
        5:       step(1, 1, 5'h10, ($urandom_range(0, 3) << 1) | ($urandom_range(0, 3) != 0));
        6:       step(1, 1, 5'h00, $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFE : $urandom_range(0, 64));
        7:       step(1, 1, 5'h04, $urandom_range(0, 2));
        default: step($urandom_range(0, 1), 0, 5'h00, 0);
      endcase
    end
    // asynchronous reset with interrupt high and a read response in flight
    step(1, 1, 5'h0C, 0);
    step(1, 1, 5'h08, 0);
    step(1, 1, 5'h10, 1);
    step(0, 0, 0, 0);
    step(1, 0, 5'h08, 0);
    chk("pre_rst_irq", 64'(interrupt), 64'd1);
    chk("pre_rst_rvalid", 64'(rvalid), 64'd1);
    #2 rst = 0;
    #1;
    chk("async_irq", 64'(interrupt), 64'd0);
    chk("async_rvalid", 64'(rvalid), 64'd0);
    chk("async_rdata", 64'(rdata), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    for (int i = 0; i <= 16; i += 4) step(1, 0, 5'(i), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
